// File: rtl/systolic_mac_array_if.sv
// Handshake/bus bundle for the systolic MAC array: skewed operand beats in, drained result rows out.
// master = upstream producer / result consumer, slave = the array itself.
interface systolic_mac_array_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;

  logic                          in_valid;
  logic [MAX_DIM*DATA_WIDTH-1:0] vector_a;
  logic [MAX_DIM*DATA_WIDTH-1:0] vector_b;
  logic                          busy;
  logic                          result_valid;
  logic [MAX_DIM*DATA_WIDTH-1:0] result_row;
  logic [7:0]                    result_row_idx;
  logic                          done;

  modport master (
    output in_valid, vector_a, vector_b,
    input  busy, result_valid, result_row, result_row_idx, done
  );

  modport slave (
    input  in_valid, vector_a, vector_b,
    output busy, result_valid, result_row, result_row_idx, done
  );
endinterface

// File: rtl/systolic_mac_array.sv
// Output-stationary MAX_DIM x MAX_DIM systolic multiply array: accumulates C = A x B from skewed
// edge streams, drains C one row per cycle, then pulses done and clears itself for the next operation.
//
// state   | meaning
// IDLE    | waiting for the first valid beat; that edge is already MAC edge 0
// COMPUTE | MAC every edge, zeros injected when in_valid is low
// DRAIN   | one accumulator row registered to result_row per edge
// DONE    | done pulse registered, accumulators and operand pipeline cleared
module systolic_mac_array #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64
) (
  input  logic                clk,
  input  logic                reset,
  systolic_mac_array_if.slave bus
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam logic [7:0] LAST_MAC = 8'(3 * MAX_DIM - 3);
  localparam logic [7:0] LAST_ROW = 8'(MAX_DIM - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, DONE} state_t;

  state_t state_q, state_d;
  logic   mac_en;
  logic   clr_en;
  logic   start;

  logic [7:0] mac_cnt;
  logic [7:0] row_cnt;

  logic [DATA_WIDTH-1:0] acc   [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0] a_reg [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0] b_reg [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0] a_in  [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0] b_in  [MAX_DIM][MAX_DIM];

  logic [MAX_DIM*DATA_WIDTH-1:0] row_sel;

  assign start = (state_q == IDLE) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mac_en  = 1'b0;
    clr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mac_en  = 1'b1;
          // a 1x1 array finishes its only product on edge 0
          state_d = (LAST_MAC == 8'd0) ? DRAIN : COMPUTE;
        end
      end
      COMPUTE: begin
        mac_en = 1'b1;
        if (mac_cnt == LAST_MAC) state_d = DRAIN;
      end
      DRAIN: begin
        if (row_cnt == LAST_ROW) state_d = DONE;
      end
      DONE: begin
        clr_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // mac_cnt holds the index of the MAC edge about to happen while in COMPUTE
  always_ff @(posedge clk) begin
    if (reset) begin
      mac_cnt <= '0;
      row_cnt <= '0;
    end else begin
      if (start)                    mac_cnt <= 8'd1;
      else if (state_q == COMPUTE)  mac_cnt <= mac_cnt + 8'd1;
      else if (state_q == DONE)     mac_cnt <= '0;

      if (state_q == DRAIN) row_cnt <= row_cnt + 8'd1;
      else                  row_cnt <= '0;
    end
  end

  for (genvar i = 0; i < MAX_DIM; i++) begin : g_row
    for (genvar j = 0; j < MAX_DIM; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_in[i][j] = bus.in_valid ? bus.vector_a[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      end else begin : g_a_inner
        assign a_in[i][j] = a_reg[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in[i][j] = bus.in_valid ? bus.vector_b[j*DATA_WIDTH +: DATA_WIDTH] : '0;
      end else begin : g_b_inner
        assign b_in[i][j] = b_reg[i-1][j];
      end

      always_ff @(posedge clk) begin
        if (reset || clr_en) begin
          acc[i][j]   <= '0;
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end else if (mac_en) begin
          acc[i][j]   <= acc[i][j] + a_in[i][j] * b_in[i][j];
          a_reg[i][j] <= a_in[i][j];
          b_reg[i][j] <= b_in[i][j];
        end
      end
    end
  end

  always_comb begin
    row_sel = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      if (row_cnt == 8'(i)) begin
        for (int j = 0; j < MAX_DIM; j++) begin
          row_sel[j*DATA_WIDTH +: DATA_WIDTH] = acc[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.busy           <= 1'b0;
      bus.result_valid   <= 1'b0;
      bus.result_row     <= '0;
      bus.result_row_idx <= '0;
      bus.done           <= 1'b0;
    end else begin
      bus.done         <= (state_q == DONE);
      bus.result_valid <= (state_q == DRAIN);
      if (state_q == DRAIN) begin
        bus.result_row     <= row_sel;
        bus.result_row_idx <= row_cnt;
      end
      if (start)                 bus.busy <= 1'b1;
      else if (state_q == DONE)  bus.busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for the 2x2 systolic MAC array: hand-computed products, wrap, reset, back-to-back.
module tb_systolic_mac_array;
  logic clk;
  logic reset;

  systolic_mac_array_if #(.DATA_WIDTH(32), .BUS_WIDTH(64)) bus ();

  systolic_mac_array #(.DATA_WIDTH(32), .BUS_WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] beat_a [8];
  logic [63:0] beat_b [8];

  logic [63:0] cap_row [4];
  int          cap_idx [4];
  int          n_rv, n_done, first_rv, done_edge, overlap;
  logic        busy_e0, busy_at_done;

  function automatic logic [63:0] pk(input logic [31:0] x0, input logic [31:0] x1);
    return {x1, x0};
  endfunction

  task automatic clear_beats();
    for (int k = 0; k < 8; k++) begin
      beat_a[k] = '0;
      beat_b[k] = '0;
    end
  endtask

  task automatic load_test1();
    clear_beats();
    beat_a[0] = pk(1, 0); beat_b[0] = pk(5, 0);
    beat_a[1] = pk(2, 3); beat_b[1] = pk(7, 6);
    beat_a[2] = pk(0, 4); beat_b[2] = pk(0, 8);
  endtask

  // Drives one operation starting at the next edge and records what the array produces.
  task automatic run_op(input int n_valid, input int pulse_lo, input int pulse_hi, input int tail);
    n_rv = 0; n_done = 0; first_rv = -1; done_edge = -1; overlap = 0;
    busy_e0 = 1'b0; busy_at_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cap_row[k] = '0;
      cap_idx[k] = -1;
    end
    for (int e = 0; e < 40; e++) begin
      if (e < n_valid) begin
        bus.in_valid = 1'b1;
        bus.vector_a = beat_a[e % 8];
        bus.vector_b = beat_b[e % 8];
      end else if (e >= pulse_lo && e <= pulse_hi) begin
        bus.in_valid = 1'b1;
        bus.vector_a = 64'h0000_0011_0000_0013;
        bus.vector_b = 64'h0000_0017_0000_001D;
      end else begin
        bus.in_valid = 1'b0;
        bus.vector_a = '0;
        bus.vector_b = '0;
      end
      @(posedge clk);
      @(negedge clk);
      if (e == 0) busy_e0 = bus.busy;
      if (bus.result_valid) begin
        if (first_rv < 0) first_rv = e;
        if (n_rv < 4) begin
          cap_row[n_rv] = bus.result_row;
          cap_idx[n_rv] = int'(bus.result_row_idx);
        end
        n_rv++;
      end
      if (bus.done) begin
        n_done++;
        if (done_edge < 0) begin
          done_edge    = e;
          busy_at_done = bus.busy;
        end
      end
      if (bus.done && bus.result_valid) overlap++;
      if (done_edge >= 0 && e >= done_edge + tail) break;
    end
    bus.in_valid = 1'b0;
    bus.vector_a = '0;
    bus.vector_b = '0;
    if (done_edge < 0) begin
      checks++; errors++;
      $display("FAIL run_op_timeout: no done pulse within 40 edges");
    end
  endtask

  task automatic check_test1_results(input string tag);
    checks++;
    if (cap_row[0] !== pk(19, 22)) begin errors++; $display("FAIL %s_row0: got %h want %h", tag, cap_row[0], pk(19, 22)); end
    checks++;
    if (cap_idx[0] !== 0) begin errors++; $display("FAIL %s_idx0: got %0d want 0", tag, cap_idx[0]); end
    checks++;
    if (cap_row[1] !== pk(43, 50)) begin errors++; $display("FAIL %s_row1: got %h want %h", tag, cap_row[1], pk(43, 50)); end
    checks++;
    if (cap_idx[1] !== 1) begin errors++; $display("FAIL %s_idx1: got %0d want 1", tag, cap_idx[1]); end
    checks++;
    if (n_rv !== 2) begin errors++; $display("FAIL %s_nrows: got %0d want 2", tag, n_rv); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.vector_a = '0; bus.vector_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.result_valid, bus.done} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.result_valid, bus.done});
    end
    checks++;
    if (bus.result_row !== 64'd0) begin errors++; $display("FAIL reset_row: got %h want 0", bus.result_row); end
    checks++;
    if (bus.result_row_idx !== 8'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.result_row_idx); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_test1();
    run_op(3, -1, -1, 2);
    check_test1_results("basic");
    checks++;
    if (first_rv !== 4) begin errors++; $display("FAIL basic_first_edge: got %0d want 4", first_rv); end
    checks++;
    if (done_edge !== 6) begin errors++; $display("FAIL basic_done_edge: got %0d want 6", done_edge); end
    checks++;
    if (busy_e0 !== 1'b1) begin errors++; $display("FAIL basic_busy_e0: got %b want 1", busy_e0); end
    checks++;
    if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b want 0", busy_at_done); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", n_done); end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL basic_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_wrap();
    clear_beats();
    beat_a[0] = pk(32'hFFFF_FFFF, 0);
    beat_b[0] = pk(2, 0);
    run_op(3, -1, -1, 0);
    checks++;
    if (cap_row[0] !== pk(32'hFFFF_FFFE, 0)) begin
      errors++; $display("FAIL wrap_row0: got %h want %h", cap_row[0], pk(32'hFFFF_FFFE, 0));
    end
    checks++;
    if (cap_row[1] !== 64'd0) begin errors++; $display("FAIL wrap_row1: got %h want 0", cap_row[1]); end
  endtask

  task automatic test_reset_mid();
    load_test1();
    for (int e = 0; e < 3; e++) begin
      bus.in_valid = 1'b1;
      bus.vector_a = beat_a[e];
      bus.vector_b = beat_b[e];
      if (e == 2) reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.vector_a = '0; bus.vector_b = '0;
    checks++;
    if ({bus.busy, bus.result_valid, bus.done} !== 3'b000 || bus.result_row !== 64'd0) begin
      errors++; $display("FAIL midreset_outputs: got flags %b row %h want 000 and 0",
                         {bus.busy, bus.result_valid, bus.done}, bus.result_row);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: busy got %b want 0", bus.busy); end
    run_op(3, -1, -1, 0);
    check_test1_results("midreset_rerun");
  endtask

  task automatic test_long_valid();
    load_test1();
    run_op(5, -1, -1, 2);
    check_test1_results("longvalid");
  endtask

  task automatic test_back_to_back();
    load_test1();
    run_op(3, -1, -1, 0);
    check_test1_results("b2b_first");
    clear_beats();
    beat_a[0] = pk(1, 0); beat_b[0] = pk(9, 0);
    beat_a[1] = pk(0, 0); beat_b[1] = pk(7, 8);
    beat_a[2] = pk(0, 1); beat_b[2] = pk(0, 6);
    run_op(3, -1, -1, 1);
    checks++;
    if (cap_row[0] !== pk(9, 8)) begin errors++; $display("FAIL b2b_row0: got %h want %h", cap_row[0], pk(9, 8)); end
    checks++;
    if (cap_row[1] !== pk(7, 6)) begin errors++; $display("FAIL b2b_row1: got %h want %h", cap_row[1], pk(7, 6)); end
    checks++;
    if (first_rv !== 4) begin errors++; $display("FAIL b2b_first_edge: got %0d want 4", first_rv); end
  endtask

  task automatic test_drain_pulse();
    load_test1();
    run_op(3, 4, 5, 3);
    check_test1_results("drainpulse");
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL drainpulse_done_count: got %0d want 1", n_done); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL drainpulse_busy_after: got %b want 0", bus.busy); end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.vector_a = '0;
    bus.vector_b = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_reset_mid();
    test_long_valid();
    test_back_to_back();
    test_drain_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
